// File: rtl/game_pkg.sv
// Shared types and constants for the game-round sequencer.
package game_pkg;

    localparam int unsigned NUM_BUTTONS   = 4;
    localparam int unsigned AREA_NONE_MIN = 4;
    localparam int unsigned AREA_W        = 3;
    localparam int unsigned SCORE_W       = 8;
    localparam int unsigned MISS_W        = 4;
    localparam int unsigned SEC_W         = 8;
    localparam int unsigned REASON_W      = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [REASON_W-1:0] {
        R_NONE = 2'd0,
        R_HITS = 2'd1,
        R_MISS = 2'd2,
        R_TIME = 2'd3
    } reason_t;

    // True when exactly one bit of the press vector is set.
    function automatic logic is_one_hot(input logic [NUM_BUTTONS-1:0] v);
        return (v != '0) && ((v & (v - NUM_BUTTONS'(1))) == '0);
    endfunction

endpackage

// File: rtl/round_ctrl_if.sv
// Player/board-facing signals of the round sequencer.
interface round_ctrl_if;
    import game_pkg::*;

    logic                   switch;
    logic [NUM_BUTTONS-1:0] button;
    logic [AREA_W-1:0]      area;
    logic                   finish;
    logic                   playing;
    logic [SCORE_W-1:0]     score;
    logic [MISS_W-1:0]      misses;
    logic [SEC_W-1:0]       sec_left;
    logic [REASON_W-1:0]    reason;

    // Board side: drives switch/buttons/area, observes round status.
    modport master (
        output switch, button, area,
        input  finish, playing, score, misses, sec_left, reason
    );

    // Sequencer side.
    modport slave (
        input  switch, button, area,
        output finish, playing, score, misses, sec_left, reason
    );

endinterface

// File: rtl/btn_edge.sv
// Button synchronizer and rising-edge detector; one press per button push.
module btn_edge
    import game_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_i,
    output logic [NUM_BUTTONS-1:0] press_c_o
);

    logic [NUM_BUTTONS-1:0] s1_q;
    logic [NUM_BUTTONS-1:0] s2_q;
    logic [NUM_BUTTONS-1:0] s3_q;

    // Two-flop synchronizer followed by a history flop for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= button_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign press_c_o = s2_q & ~s3_q;

endmodule

// File: rtl/round_ctrl.sv
// Game-round sequencer: scores button presses against the lit area and
// ends the round on hit limit, miss limit or timeout.
module round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 50000000,
    parameter int unsigned TIME_LIMIT  = 60,
    parameter int unsigned HIT_LIMIT   = 20,
    parameter int unsigned MISS_LIMIT  = 5
) (
    input  logic          clock,
    input  logic          reset,
    round_ctrl_if.slave   bus
);

    localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

    state_t             state_q;
    logic               finish_q;
    logic               playing_q;
    logic [SCORE_W-1:0] score_q;
    logic [MISS_W-1:0]  misses_q;
    logic [SEC_W-1:0]   sec_q;
    reason_t            reason_q;
    logic [PW-1:0]      presc_q;

    logic [SCORE_W-1:0] score_d;
    logic [MISS_W-1:0]  misses_d;
    logic [SEC_W-1:0]   sec_d;
    logic [PW-1:0]      presc_d;
    reason_t            end_reason_c;
    logic               hit_c;
    logic               miss_c;
    logic               tick_c;

    logic [NUM_BUTTONS-1:0] press_c;

    btn_edge u_btn_edge (
        .clock     (clock),
        .reset     (reset),
        .button_i  (bus.button),
        .press_c_o (press_c)
    );

    // Candidate counter updates for a PLAY cycle and the resulting end cause.
    always_comb begin
        hit_c        = 1'b0;
        miss_c       = 1'b0;
        score_d      = score_q;
        misses_d     = misses_q;
        sec_d        = sec_q;
        presc_d      = presc_q + PW'(1);
        tick_c       = (presc_q == PW'(CLK_PER_SEC - 1));
        end_reason_c = R_NONE;

        if (press_c != '0) begin
            if (is_one_hot(press_c) && (bus.area < AREA_W'(AREA_NONE_MIN))
                && press_c[bus.area[1:0]]) begin
                hit_c = 1'b1;
            end else begin
                miss_c = 1'b1;
            end
        end

        if (hit_c && (score_q < SCORE_W'(HIT_LIMIT))) begin
            score_d = score_q + SCORE_W'(1);
        end
        if (miss_c && (misses_q < MISS_W'(MISS_LIMIT))) begin
            misses_d = misses_q + MISS_W'(1);
        end

        if (tick_c) begin
            presc_d = '0;
            if (sec_q != '0) begin
                sec_d = sec_q - SEC_W'(1);
            end
        end

        if (score_d == SCORE_W'(HIT_LIMIT)) begin
            end_reason_c = R_HITS;
        end else if (misses_d == MISS_W'(MISS_LIMIT)) begin
            end_reason_c = R_MISS;
        end else if (sec_d == '0) begin
            end_reason_c = R_TIME;
        end
    end

    // Round FSM with registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            finish_q  <= 1'b0;
            playing_q <= 1'b0;
            score_q   <= '0;
            misses_q  <= '0;
            sec_q     <= SEC_W'(TIME_LIMIT);
            reason_q  <= R_NONE;
            presc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.switch) begin
                        state_q <= S_ARM;
                    end
                end
                S_ARM: begin
                    score_q  <= '0;
                    misses_q <= '0;
                    reason_q <= R_NONE;
                    presc_q  <= '0;
                    sec_q    <= SEC_W'(TIME_LIMIT);
                    if (bus.switch) begin
                        state_q   <= S_PLAY;
                        playing_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PLAY: begin
                    if (!bus.switch) begin
                        state_q   <= S_IDLE;
                        playing_q <= 1'b0;
                    end else begin
                        score_q  <= score_d;
                        misses_q <= misses_d;
                        sec_q    <= sec_d;
                        presc_q  <= presc_d;
                        if (end_reason_c != R_NONE) begin
                            reason_q  <= end_reason_c;
                            state_q   <= S_DONE;
                            finish_q  <= 1'b1;
                            playing_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.switch) begin
                        state_q  <= S_IDLE;
                        finish_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    finish_q  <= 1'b0;
                    playing_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.finish   = finish_q;
    assign bus.playing  = playing_q;
    assign bus.score    = score_q;
    assign bus.misses   = misses_q;
    assign bus.sec_left = sec_q;
    assign bus.reason   = reason_q;

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
Game-round sequencer for the board. It drives the shared `finish` signal consumed by the area, led and timer blocks. It edge-detects the four player buttons and scores each press against the currently lit target area. It ends the round on a hit limit, a miss limit or a time limit, and reports the cause.

Parameters:
CLK_PER_SEC, 50000000, clock cycles per game second (prescaler terminal count).
TIME_LIMIT, 60, round length in seconds (1..255).
HIT_LIMIT, 20, hits that end the round as a win (1..255).
MISS_LIMIT, 5, misses that end the round as a loss (1..15).

Ports:
clock  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
switch  input  1  round enable; a rising level starts a round, low aborts it.
button  input  4  raw player buttons, asynchronous, active-high.
area  input  3  current target from the area block; 0..3 means button[area] is the target, 4..7 means no target.
finish  output  1  high while in DONE; fans out to the area, led and timer blocks.
playing  output  1  high while in PLAY.
score  output  8  hit count for the current round.
misses  output  4  miss count for the current round.
sec_left  output  8  seconds remaining.
reason  output  2  end cause: 0 none, 1 hit limit, 2 miss limit, 3 timeout.

Behaviour:
- Reset (at a clock edge with reset=1):
  - state=IDLE; finish, playing, score, misses and reason are 0.
  - sec_left=TIME_LIMIT; prescaler=0; synchronizer flops are 0.
- States: IDLE, ARM, PLAY, DONE.
- IDLE:
  - switch=1 → ARM.
  - Outputs hold their last values, so the result stays visible after an abort or a finished round.
- ARM (exactly 1 cycle):
  - Clear score, misses, reason and prescaler; load sec_left=TIME_LIMIT.
  - → PLAY (or → IDLE if switch=0).
- PLAY: playing=1; prescaler counts every cycle.
- Button front end:
  - Per bit: s1←button, s2←s1, s3←s2; press = s2 & ~s3.
  - A button sampled high at edge k updates score/misses at edge k+2.
  - Holding a button produces exactly one press.
- Scoring, evaluated once per cycle in PLAY:
  - Hit: press is one-hot, area<4, and the pressed index equals area[1:0]. score+1.
  - Any other nonzero press (wrong button, several buttons, or area≥4) is a miss. misses+1, one miss per cycle at most.
  - No press: no change. Counters never wrap; they saturate at their limit.
- Timer:
  - When prescaler reaches CLK_PER_SEC-1 it resets to 0 and sec_left decrements.
  - sec_left reaching 0 is a timeout.
- End conditions, checked on the updated values:
  - score==HIT_LIMIT → reason=1.
  - Else misses==MISS_LIMIT → reason=2.
  - Else sec_left==0 → reason=3.
  - Any end condition: → DONE on the same edge.
  - Priority on simultaneous events: hit > miss > timeout.
- DONE:
  - finish=1; score, misses, sec_left and reason are frozen; button presses are ignored.
  - switch=0 → IDLE with finish=0.
  - A new round needs switch to fall and then rise again.
- switch=0 while in PLAY or ARM: → IDLE next edge. This is an abort; reason stays 0 and finish is never asserted.
- Reset mid-round overrides everything and returns all outputs to reset values.
- finish, playing and reason are registered, with no combinational path from inputs.

Decomposition:
- Package game_pkg:
  - State encoding (IDLE=0, ARM=1, PLAY=2, DONE=3).
  - Reason codes (R_NONE, R_HITS, R_MISS, R_TIME).
  - AREA_NONE_MIN=4 and NUM_BUTTONS=4.
- Sub-module btn_edge: a 4-bit two-flop synchronizer plus rising-edge detector, output press[3:0], reset by the same synchronous reset.
- The remaining FSM, counters and prescaler live in round_ctrl.

Test Plan (CLK_PER_SEC=4, TIME_LIMIT=3, HIT_LIMIT=2, MISS_LIMIT=2):
- Reset, then switch=1: ARM for 1 cycle, then playing=1, sec_left=3, score=0, finish=0.
- area=2, pulse button=4'b0100 for 5 cycles twice: score 0→1→2, exactly one increment per pulse, each 3 edges after the rise. The second hit gives finish=1, reason=1; a further button press leaves score=2.
- area=1, press button[3], then button[0]|button[1] together: misses=2 → finish=1, reason=2, score=0.
- No presses: sec_left 3→2→1→0 at 4-cycle intervals; finish=1, reason=3 exactly 12 cycles after entering PLAY.
- Hit and timeout on the same edge with score=1: reason=1. switch=0 mid-PLAY: IDLE, finish never 1, reason=0.
- Assert reset during DONE: all outputs return to reset values next edge, with sec_left=3.
